// File: rtl/hvpi_pkg.sv
// ----------------------------------------------------------------------------
// hvpi_pkg
// Shared constants, types and helpers for the hardware vectored priority
// interrupt controller (hvpi_sys) and its priority encoder.
//   NUM_INTS    : number of interrupt sources (design is fixed at 4)
//   ADDR_W      : width of the ISR vector address
//   DEFAULT_VEC : vector reported when nothing is pending or output is forced
//   VEC_BASE    : offset added to a source index to form its vector
// ----------------------------------------------------------------------------
package hvpi_pkg;

    localparam int NUM_INTS = 4;
    localparam int ADDR_W   = 16;
    localparam int VEC_BASE = 1;

    localparam logic [ADDR_W-1:0] DEFAULT_VEC = 16'd1;

    // Bundled encoder result, handy when passing the encoder outcome around.
    typedef struct packed {
        logic              valid;
        logic [1:0]        index;
        logic [ADDR_W-1:0] vector;
    } pri_enc_t;

    // Source index to ISR vector address (index + VEC_BASE).
    function automatic logic [ADDR_W-1:0] idx_to_vec(input logic [1:0] idx);
        return ADDR_W'(idx) + ADDR_W'(VEC_BASE);
    endfunction

endpackage

// File: rtl/hvpi_pri_enc.sv
// ----------------------------------------------------------------------------
// hvpi_pri_enc
// Combinational 4-input priority encoder; bit 0 has the highest priority.
// Ports:
//   act    in  [NUM_INTS-1:0] masked, active interrupt requests
//   valid  out                at least one request is active
//   index  out [1:0]          index of the winning request (0 when none)
//   vector out [ADDR_W-1:0]   ISR vector of the winner, DEFAULT_VEC when none
// ----------------------------------------------------------------------------
module hvpi_pri_enc
    import hvpi_pkg::*;
(
    input  logic [NUM_INTS-1:0] act,
    output logic                valid,
    output logic [1:0]          index,
    output logic [ADDR_W-1:0]   vector
);

    pri_enc_t enc;

    // Scan from the lowest-priority source downwards so that the last hit,
    // i.e. the lowest index, is the one that sticks.
    always_comb begin
        enc.valid  = 1'b0;
        enc.index  = 2'd0;
        for (int i = NUM_INTS - 1; i >= 0; i--) begin
            if (act[i]) begin
                enc.valid = 1'b1;
                enc.index = 2'(i);
            end
        end
        enc.vector = enc.valid ? idx_to_vec(enc.index) : DEFAULT_VEC;
    end

    assign valid  = enc.valid;
    assign index  = enc.index;
    assign vector = enc.vector;

endmodule

// File: rtl/hvpi_sys.sv
// ----------------------------------------------------------------------------
// hvpi_sys
// 4-source vectored priority interrupt controller. Requests and an enable
// mask are latched into registers; the masked requests are priority encoded
// into a registered ISR vector address and a registered pending flag.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   ints[3:0]         raw interrupt request lines
//   intMask[3:0]      mask value to load (1 = enabled)
//   ldIntReg/ldMask   load ints / intMask into their registers
//   clrIntReg/clrMask active-low clears of the registers (clear beats load)
//   clrPend           active-low suppression of intPending only
//   intDisable        global disable, forces default vector and no pending
//   isrAddr[15:0]     registered ISR vector address
//   intPending        registered interrupt-pending flag
//   test_intReg, test_maskReg, priEncOut, test_wIntPending  bring-up taps
// ----------------------------------------------------------------------------
module hvpi_sys
    import hvpi_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_INTS-1:0] ints,
    input  logic [NUM_INTS-1:0] intMask,
    input  logic                ldIntReg,
    input  logic                clrIntReg,
    input  logic                ldMask,
    input  logic                clrMask,
    input  logic                clrPend,
    input  logic                intDisable,
    output logic [ADDR_W-1:0]   isrAddr,
    output logic                intPending,
    output logic [NUM_INTS-1:0] test_intReg,
    output logic [NUM_INTS-1:0] test_maskReg,
    output logic [2:0]          priEncOut,
    output logic                test_wIntPending
);

    logic [NUM_INTS-1:0] int_reg_q,  int_reg_d;
    logic [NUM_INTS-1:0] mask_reg_q, mask_reg_d;
    logic [ADDR_W-1:0]   isr_addr_q, isr_addr_d;
    logic                int_pending_q, int_pending_d;

    logic [NUM_INTS-1:0] act;
    logic                enc_valid;
    logic [1:0]          enc_index;
    logic [ADDR_W-1:0]   enc_vector;

    // The encoder sees the registered values, so a fresh load only shows up
    // on the outputs one edge later.
    assign act = int_reg_q & mask_reg_q;

    hvpi_pri_enc u_pri_enc (
        .act    (act),
        .valid  (enc_valid),
        .index  (enc_index),
        .vector (enc_vector)
    );

    // Next-state for the request/mask registers and the vector outputs.
    // Either clear, or the global disable, forces the default vector; clrPend
    // only hides the pending flag while still tracking the vector.
    always_comb begin
        int_reg_d = int_reg_q;
        if (!clrIntReg) begin
            int_reg_d = '0;
        end else if (ldIntReg) begin
            int_reg_d = ints;
        end

        mask_reg_d = mask_reg_q;
        if (!clrMask) begin
            mask_reg_d = '0;
        end else if (ldMask) begin
            mask_reg_d = intMask;
        end

        isr_addr_d    = DEFAULT_VEC;
        int_pending_d = 1'b0;
        if (clrIntReg && clrMask && !intDisable) begin
            isr_addr_d    = enc_vector;
            int_pending_d = clrPend & enc_valid;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            int_reg_q     <= '0;
            mask_reg_q    <= '0;
            isr_addr_q    <= DEFAULT_VEC;
            int_pending_q <= 1'b0;
        end else begin
            int_reg_q     <= int_reg_d;
            mask_reg_q    <= mask_reg_d;
            isr_addr_q    <= isr_addr_d;
            int_pending_q <= int_pending_d;
        end
    end

    assign isrAddr          = isr_addr_q;
    assign intPending       = int_pending_q;
    assign test_intReg      = int_reg_q;
    assign test_maskReg     = mask_reg_q;
    assign priEncOut        = {enc_valid, enc_index};
    assign test_wIntPending = enc_valid;

endmodule

// File: tb/tb_hvpi_sys.sv
// ----------------------------------------------------------------------------
// tb_hvpi_sys
// Self-checking bench for hvpi_sys: a behavioural model tracks the expected
// register contents and outputs, a compare process checks every cycle, and
// a directed sequence pins a few hand-computed values.
// ----------------------------------------------------------------------------
module tb_hvpi_sys;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  ints;
    logic [3:0]  intMask;
    logic        ldIntReg;
    logic        clrIntReg;
    logic        ldMask;
    logic        clrMask;
    logic        clrPend;
    logic        intDisable;
    logic [15:0] isrAddr;
    logic        intPending;
    logic [3:0]  test_intReg;
    logic [3:0]  test_maskReg;
    logic [2:0]  priEncOut;
    logic        test_wIntPending;

    int checks = 0;
    int errors = 0;

    // Model state: what the DUT registers must hold after the latest edge.
    logic [3:0]  m_int;
    logic [3:0]  m_mask;
    logic [15:0] m_addr;
    logic        m_pend;
    bit          m_valid = 1'b0;

    hvpi_sys dut (
        .clk              (clk),
        .rst              (rst),
        .ints             (ints),
        .intMask          (intMask),
        .ldIntReg         (ldIntReg),
        .clrIntReg        (clrIntReg),
        .ldMask           (ldMask),
        .clrMask          (clrMask),
        .clrPend          (clrPend),
        .intDisable       (intDisable),
        .isrAddr          (isrAddr),
        .intPending       (intPending),
        .test_intReg      (test_intReg),
        .test_maskReg     (test_maskReg),
        .priEncOut        (priEncOut),
        .test_wIntPending (test_wIntPending)
    );

    always #5 clk = ~clk;

    // Lowest set bit wins; -1 means nothing is active.
    function automatic int lowestActive(input logic [3:0] a);
        for (int i = 0; i < 4; i++) begin
            if (a[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [15:0] vectorOf(input logic [3:0] a);
        int w;
        w = lowestActive(a);
        return (w < 0) ? 16'd1 : 16'(w + 1);
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [3:0] i,
                                 input logic [3:0] m, input logic ld,
                                 input logic clr, input logic ldm,
                                 input logic clrm, input logic cp,
                                 input logic dis);
        rst        = r;
        ints       = i;
        intMask    = m;
        ldIntReg   = ld;
        clrIntReg  = clr;
        ldMask     = ldm;
        clrMask    = clrm;
        clrPend    = cp;
        intDisable = dis;
        @(posedge clk);
        #1;
    endtask

    // Idle cycle: no loads, no clears, pending visible, interrupts enabled.
    task automatic idle();
        applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    // Behavioural model, advanced on every rising edge from the inputs.
    always @(posedge clk) begin
        logic [3:0] a;
        if (rst) begin
            m_int   = 4'h0;
            m_mask  = 4'h0;
            m_addr  = 16'd1;
            m_pend  = 1'b0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            a = m_int & m_mask;
            if (!clrIntReg || !clrMask || intDisable) begin
                m_addr = 16'd1;
                m_pend = 1'b0;
            end else begin
                m_addr = vectorOf(a);
                m_pend = clrPend && (a != 4'h0);
            end
            m_int  = !clrIntReg ? 4'h0 : (ldIntReg ? ints : m_int);
            m_mask = !clrMask ? 4'h0 : (ldMask ? intMask : m_mask);
        end
    end

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        logic [3:0] a;
        int         w;
        if (m_valid) begin
            a = m_int & m_mask;
            w = lowestActive(a);
            checkOutput("isrAddr", isrAddr, m_addr);
            checkOutput("intPending", {15'b0, intPending}, {15'b0, m_pend});
            checkOutput("test_intReg", {12'b0, test_intReg}, {12'b0, m_int});
            checkOutput("test_maskReg", {12'b0, test_maskReg}, {12'b0, m_mask});
            checkOutput("priEncOut", {13'b0, priEncOut},
                        (w < 0) ? 16'd0 : 16'(4 + w));
            checkOutput("test_wIntPending", {15'b0, test_wIntPending},
                        {15'b0, (a != 4'h0)});
        end
    end

    initial begin
        logic [13:0] key;
        logic [13:0] b;

        // Reset with arbitrary other inputs.
        applyStimulus(1'b1, 4'hF, 4'hF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("rst_isrAddr", isrAddr, 16'd1);
        checkOutput("rst_intPending", {15'b0, intPending}, 16'd0);
        checkOutput("rst_intReg", {12'b0, test_intReg}, 16'd0);
        checkOutput("rst_maskReg", {12'b0, test_maskReg}, 16'd0);

        // Single source: load mask 1111 and request 0100 together.
        applyStimulus(1'b0, 4'b0100, 4'b1111, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("single_wPend", {15'b0, test_wIntPending}, 16'd1);
        checkOutput("single_priEnc", {13'b0, priEncOut}, 16'h6);
        checkOutput("single_isrAddr_N", isrAddr, 16'd1);
        idle();
        checkOutput("single_isrAddr_N1", isrAddr, 16'd3);
        checkOutput("single_intPending_N1", {15'b0, intPending}, 16'd1);

        // Priority between sources 1 and 3, then mask down to source 3.
        applyStimulus(1'b0, 4'b1010, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        idle();
        checkOutput("prio_isrAddr", isrAddr, 16'd2);
        checkOutput("prio_priEnc", {13'b0, priEncOut}, 16'h5);
        applyStimulus(1'b0, 4'h0, 4'b1000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        idle();
        checkOutput("mask_isrAddr", isrAddr, 16'd4);
        checkOutput("mask_intPending", {15'b0, intPending}, 16'd1);

        // Suppression by clrPend and by intDisable.
        applyStimulus(1'b0, 4'b0100, 4'b1111, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        idle();
        applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("clrPend_isrAddr", isrAddr, 16'd3);
        checkOutput("clrPend_intPending", {15'b0, intPending}, 16'd0);
        applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        checkOutput("disable_isrAddr", isrAddr, 16'd1);
        checkOutput("disable_intPending", {15'b0, intPending}, 16'd0);

        // Clear precedence over load.
        applyStimulus(1'b0, 4'hF, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("clrInt_intReg", {12'b0, test_intReg}, 16'd0);
        checkOutput("clrInt_isrAddr", isrAddr, 16'd1);
        checkOutput("clrInt_maskReg", {12'b0, test_maskReg}, 16'hF);
        applyStimulus(1'b0, 4'b0110, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("clrMask_intReg", {12'b0, test_intReg}, 16'h6);
        checkOutput("clrMask_maskReg", {12'b0, test_maskReg}, 16'd0);
        checkOutput("clrMask_intPending", {15'b0, intPending}, 16'd0);

        // Sweep every combination of the 14 control/data bits, visited in
        // an order scrambled by a random key.
        key = 14'($urandom_range(0, 16383));
        $display("[TB] sweep key %0h", key);
        for (int v = 0; v < 16384; v++) begin
            b = 14'(v) ^ key;
            applyStimulus(1'b0, b[10:7], b[5:2], b[12], b[0], b[11], b[1],
                          b[13], b[6]);
        end

        // Random traffic, including occasional resets, biased towards
        // clears being inactive so pending requests can build up.
        for (int n = 0; n < 2000; n++) begin
            applyStimulus(($urandom_range(0, 63) == 0),
                          4'($urandom), 4'($urandom),
                          1'($urandom), ($urandom_range(0, 3) != 0),
                          1'($urandom), ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 3) == 0));
        end

        idle();
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hvpi_sys.md
Name: hvpi_sys

Overview:
- 4-source hardware vectored priority interrupt controller.
- Latches interrupt requests and an enable mask into internal registers.
- Priority-encodes the masked requests into a registered 16-bit ISR vector address and a registered interrupt-pending flag for the CPU control unit.
- Exposes internal state on test ports for bring-up and verification.

Parameters:
- NUM_INTS, 4, number of interrupt sources (the design is fixed at 4; the parameter documents the width).
- ADDR_W, 16, ISR address width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ints  in  4  raw interrupt request lines.
- intMask  in  4  mask value to load; 1 = enabled.
- ldIntReg  in  1  load ints into intReg.
- clrIntReg  in  1  active-low clear of intReg.
- ldMask  in  1  load intMask into maskReg.
- clrMask  in  1  active-low clear of maskReg.
- clrPend  in  1  active-low suppress of intPending; the vector is still computed.
- intDisable  in  1  global interrupt disable, active-high.
- isrAddr  out  16  registered ISR vector address.
- intPending  out  1  registered interrupt-pending flag.
- test_intReg  out  4  current intReg contents.
- test_maskReg  out  4  current maskReg contents.
- priEncOut  out  3  combinational priority-encoder output.
- test_wIntPending  out  1  combinational: (intReg & maskReg) != 0.

Behaviour:
- All state is updated on the rising edge of clk. Sequential elements are intReg[3:0], maskReg[3:0], isrAddr[15:0] and intPending.
- Reset (rst=1, synchronous) takes priority over everything:
  - intReg=0, maskReg=0.
  - isrAddr=16'd1, intPending=0.
- intReg next value:
  - clrIntReg==0 -> 0 (clear dominates load).
  - else ldIntReg -> ints.
  - else hold.
- maskReg next value:
  - clrMask==0 -> 0 (clear dominates load).
  - else ldMask -> intMask.
  - else hold.
- Loads and clears of the two registers are independent. Example: clrIntReg=0 with ldMask=1 and clrMask=1 clears intReg and loads maskReg in the same cycle.
- Define act = intReg & maskReg, using the pre-edge register values.
- Define vec from act, with bit 0 highest priority:
  - act[0] -> 1
  - else act[1] -> 2
  - else act[2] -> 3
  - else act[3] -> 4
  - else 1
- isrAddr/intPending next value, evaluated in priority order with the current-cycle control inputs:
  1. clrIntReg==0 or clrMask==0 -> isrAddr=1, intPending=0.
  2. else intDisable==1 -> isrAddr=1, intPending=0.
  3. else clrPend==0 -> isrAddr=vec, intPending=0.
  4. else -> isrAddr=vec, intPending=(act!=0).
- Latency:
  - A value loaded into intReg/maskReg at edge N affects isrAddr/intPending at edge N+1.
  - Control inputs (clears, intDisable, clrPend) affect the outputs at the same edge they are sampled.
- isrAddr upper bits [15:3] are always 0.
- priEncOut (combinational from act): bit2 = (act!=0); bits[1:0] = index of the highest-priority active bit, 0 when none.
- test_intReg, test_maskReg and test_wIntPending reflect the current register state combinationally.
- No handshake: intPending stays asserted while its source remains in intReg&maskReg. Software or the control unit retires it via clrIntReg, clrPend or intDisable.
- Simultaneous requests resolve to the lowest index.

Decomposition:
- Shared package hvpi_pkg holds:
  - NUM_INTS and ADDR_W.
  - DEFAULT_VEC = 16'd1.
  - VEC_BASE = 1, giving vector = index + VEC_BASE.
- One natural sub-module: hvpi_pri_enc. It is a combinational 4-input priority encoder producing valid, index[1:0] and the 16-bit vector.

Test Plan:
- Reset: assert rst one cycle with arbitrary inputs -> isrAddr=1, intPending=0, test_intReg=0, test_maskReg=0.
- Single source:
  - Stimulus: clrs high, clrPend=1, intDisable=0; load maskReg=4'b1111 and intReg=4'b0100 at edge N.
  - Response: test_wIntPending=1 and priEncOut=3'b110 after edge N; isrAddr=3 and intPending=1 after edge N+1.
- Priority: intReg=4'b1010, maskReg=4'b1111 -> isrAddr=2, intPending=1. Then maskReg=4'b1000 -> isrAddr=4.
- Suppression:
  - With an active masked request, clrPend=0 -> isrAddr keeps the vector (e.g. 3), intPending=0.
  - intDisable=1 -> isrAddr=1, intPending=0.
- Clear precedence:
  - Stimulus: clrIntReg=0 with ldIntReg=1, ints=4'hF.
  - Response: intReg=0, isrAddr=1, intPending=0 at that edge.
  - Stimulus: clrMask=0 with ldIntReg=1 and clrIntReg=1.
  - Response: intReg loads ints, maskReg clears.
- Exhaustive sweep: iterate all combinations of clears, intMask, intDisable, ints, ldMask and ldIntReg (14 bits) against a reference model -> no mismatch on isrAddr or intPending at any cycle.
